// File: rtl/adventure_move_ctrl.sv
// Move sequencer between the board buttons and the room FSM: edge-detected
// single-step pulses, post-move lockout, sword tracking, end-of-game hold and restart.
module adventure_move_ctrl #(
    parameter int LOCKOUT     = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int MOVE_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_n,
    input  logic              btn_s,
    input  logic              btn_e,
    input  logic              btn_w,
    input  logic [6:0]        room_code,
    input  logic              win_in,
    input  logic              dead_in,
    output logic              step_n,
    output logic              step_s,
    output logic              step_e,
    output logic              step_w,
    output logic              vorpal,
    output logic              room_reset,
    output logic [MOVE_W-1:0] moves,
    output logic [2:0]        phase,
    output logic              err
);

    typedef enum logic [2:0] {
        PLAY    = 3'd0,
        ISSUE   = 3'd1,
        LOCK    = 3'd2,
        OVER    = 3'd3,
        RESTART = 3'd4
    } phase_t;

    localparam int CNT_MAX = (LOCKOUT > HOLD_CYCLES) ? LOCKOUT : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    phase_t            state, stateNext;
    logic [3:0]        prev;
    logic [3:0]        dir, dirNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [MOVE_W-1:0] movesR, movesNext;
    logic              vorpalR, vorpalNext;
    logic              errR, errNext;

    logic [3:0] btn;
    logic [3:0] rise;
    logic       multiRise;

    // Bit order throughout: [3]=north, [2]=south, [1]=east, [0]=west.
    assign btn       = {btn_n, btn_s, btn_e, btn_w};
    assign rise      = btn & ~prev;
    assign multiRise = (rise & (rise - 4'd1)) != 4'd0;

    always_comb begin
        stateNext  = state;
        dirNext    = dir;
        cntNext    = cnt;
        movesNext  = movesR;
        vorpalNext = vorpalR;
        errNext    = 1'b0;
        case (state)
            PLAY, ISSUE, LOCK: begin
                if (room_code == 7'b0001000) vorpalNext = 1'b1;
                if (win_in || dead_in) begin
                    stateNext = OVER;
                    cntNext   = CNT_W'(HOLD_CYCLES - 1);
                end else if (state == PLAY) begin
                    if (multiRise) begin
                        errNext = 1'b1;
                    end else if (rise != 4'd0) begin
                        dirNext   = rise;
                        stateNext = ISSUE;
                    end
                end else if (state == ISSUE) begin
                    if (movesR != '1) movesNext = movesR + MOVE_W'(1);
                    stateNext = LOCK;
                    cntNext   = CNT_W'(LOCKOUT - 1);
                end else begin
                    if (cnt == '0) stateNext = PLAY;
                    else           cntNext   = cnt - CNT_W'(1);
                end
            end
            OVER: begin
                if (cnt == '0) stateNext = RESTART;
                else           cntNext   = cnt - CNT_W'(1);
            end
            default: begin
                // RESTART and any illegal encoding share the same clears.
                movesNext  = '0;
                vorpalNext = 1'b0;
                cntNext    = '0;
                stateNext  = PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= PLAY;
            prev    <= 4'b1111;
            dir     <= '0;
            cnt     <= '0;
            movesR  <= '0;
            vorpalR <= 1'b0;
            errR    <= 1'b0;
        end else begin
            state   <= stateNext;
            prev    <= btn;
            dir     <= dirNext;
            cnt     <= cntNext;
            movesR  <= movesNext;
            vorpalR <= vorpalNext;
            errR    <= errNext;
        end
    end

    assign {step_n, step_s, step_e, step_w} = (state == ISSUE) ? dir : 4'd0;
    assign vorpal     = vorpalR;
    assign room_reset = reset || (state == RESTART);
    assign moves      = movesR;
    assign phase      = state;
    assign err        = errR;

endmodule
